// File: rtl/deskew_align.sv
// Re-aligns the staggered lanes of a systolic array into one parallel word.
// Lane i is delayed by (N-1-i)*STEP cycles so every lane of a sample leaves together.
module deskew_align #(
    parameter int N           = 5,
    parameter int DATA_LENGTH = 8,
    parameter int STEP        = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [N*DATA_LENGTH-1:0]    din,
    output logic                        out_valid,
    output logic [N*DATA_LENGTH-1:0]    dout,
    output logic                        busy,
    output logic [15:0]                 sample_count
);

    localparam int L = (N - 1) * STEP;

    logic [L-1:0]               vld_r;
    logic [N*DATA_LENGTH-1:0]   aligned_s;

    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam int DEPTH = (N - 1 - i) * STEP;
        if (DEPTH == 0) begin : g_direct
            assign aligned_s[i*DATA_LENGTH +: DATA_LENGTH] = din[i*DATA_LENGTH +: DATA_LENGTH];
        end else begin : g_chain
            logic [DATA_LENGTH-1:0] chain_r [DEPTH];

            // Per-lane delay line; shifts every cycle, validity travels separately.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        chain_r[j] <= {DATA_LENGTH{1'b0}};
                    end
                end else begin
                    chain_r[0] <= din[i*DATA_LENGTH +: DATA_LENGTH];
                    for (int j = 1; j < DEPTH; j++) begin
                        chain_r[j] <= chain_r[j-1];
                    end
                end
            end

            assign aligned_s[i*DATA_LENGTH +: DATA_LENGTH] = chain_r[DEPTH-1];
        end
    end

    // Valid delay line matching the deepest data lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= {L{1'b0}};
        end else begin
            vld_r[0] <= in_valid;
            for (int j = 1; j < L; j++) begin
                vld_r[j] <= vld_r[j-1];
            end
        end
    end

    // Output register: captures all lanes only for a valid slot, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            dout         <= {(N*DATA_LENGTH){1'b0}};
            sample_count <= 16'd0;
        end else begin
            out_valid <= vld_r[L-1];
            if (vld_r[L-1]) begin
                dout         <= aligned_s;
                sample_count <= sample_count + 16'd1;
            end
        end
    end

    assign busy = (|vld_r) | out_valid;

endmodule

// File: tb/tb_deskew_align.sv
// Randomized and directed bench for deskew_align, checked against a history-based
// model: the output after edge e is the sample accepted at edge e-L, lane i taken at e-L+i*STEP.
module tb_deskew_align;

    localparam int N  = 5;
    localparam int DL = 8;
    localparam int ST = 1;
    localparam int L  = (N - 1) * ST;
    localparam int H  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [N*DL-1:0]   din;
    logic              out_valid;
    logic [N*DL-1:0]   dout;
    logic              busy;
    logic [15:0]       sample_count;

    logic              rst2;
    logic              in_valid2;
    logic [23:0]       din2;
    logic              out_valid2;
    logic [23:0]       dout2;
    logic              busy2;
    logic [15:0]       sample_count2;

    int n_total = 0;
    int n_bad   = 0;

    // model state
    logic              hv [H];
    logic [N*DL-1:0]   hd [H];
    int                e        = -1;
    int                last_rst = -1;
    logic [N*DL-1:0]   m_dout   = '0;
    logic [15:0]       m_cnt    = 16'd0;
    logic              chk_en   = 1'b1;

    always #5 clk = ~clk;

    deskew_align #(.N(N), .DATA_LENGTH(DL), .STEP(ST)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .din(din),
        .out_valid(out_valid), .dout(dout), .busy(busy), .sample_count(sample_count)
    );

    deskew_align #(.N(3), .DATA_LENGTH(8), .STEP(2)) dut2 (
        .clk(clk), .rst(rst2), .in_valid(in_valid2), .din(din2),
        .out_valid(out_valid2), .dout(dout2), .busy(busy2), .sample_count(sample_count2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h (edge %0d)", tag, got, exp, e);
        end
    endtask

    function automatic logic [N*DL-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[N*DL-1:0];
    endfunction

    // One clock edge: record inputs, advance model, compare outputs shortly after the edge.
    task automatic tick();
        logic exp_ov;
        logic exp_busy;
        @(posedge clk);
        e++;
        hv[e % H] = in_valid && !rst;
        hd[e % H] = din;
        if (rst) last_rst = e;
        exp_ov = 1'b0;
        if (e - L > last_rst && e - L >= 0) exp_ov = hv[(e - L) % H];
        if (rst) begin
            m_dout = '0;
            m_cnt  = 16'd0;
        end else if (exp_ov) begin
            for (int i = 0; i < N; i++) begin
                m_dout[i*DL +: DL] = hd[(e - L + i*ST) % H][i*DL +: DL];
            end
            m_cnt = m_cnt + 16'd1;
        end
        exp_busy = 1'b0;
        for (int j = e - L; j <= e; j++) begin
            if (j >= 0 && j > last_rst && hv[j % H]) exp_busy = 1'b1;
        end
        #1;
        if (chk_en) begin
            check_eq("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
            check_eq("dout", {24'd0, dout}, {24'd0, m_dout});
            check_eq("busy", {63'd0, busy}, {63'd0, exp_busy});
            check_eq("sample_count", {48'd0, sample_count}, {48'd0, m_cnt});
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [N*DL-1:0] d);
        rst      = r;
        in_valid = v;
        din      = d;
        tick();
    endtask

    initial begin
        logic [N*DL-1:0] w;
        for (int i = 0; i < H; i++) begin
            hv[i] = 1'b0;
            hd[i] = '0;
        end
        rst = 1'b1; in_valid = 1'b0; din = '0;
        rst2 = 1'b1; in_valid2 = 1'b0; din2 = 24'd0;

        // reset with random inputs, then first cycle after release
        for (int c = 0; c < 3; c++) drive(1'b1, 1'($urandom_range(0, 1)), rand_word());
        drive(1'b0, 1'b0, rand_word());
        check_eq("post_reset_count", {48'd0, sample_count}, 64'd0);

        // single sample, lanes staggered one cycle apart
        for (int c = 0; c < 10; c++) begin
            w = rand_word();
            if (c < N) w[c*DL +: DL] = 8'(8'h11 * (c + 1));
            drive(1'b0, c == 0, w);
            if (c == L) begin
                check_eq("single_dout", {24'd0, dout}, 64'h0000_0055_4433_2211);
                check_eq("single_count", {48'd0, sample_count}, 64'd1);
            end
        end

        // eight back-to-back samples, lane i of sample s = 16*s+i
        for (int c = 0; c < 14; c++) begin
            w = rand_word();
            for (int i = 0; i < N; i++) begin
                if (c - i >= 0 && c - i < 8) w[i*DL +: DL] = 8'(16 * (c - i) + i);
            end
            drive(1'b0, c < 8, w);
            if (c == L + 7) check_eq("b2b_last_dout", {24'd0, dout}, 64'h0000_0074_7372_7170);
        end
        check_eq("b2b_count", {48'd0, sample_count}, 64'd9);

        // gapped pattern 1,0,0,1
        for (int c = 0; c < 10; c++) drive(1'b0, (c == 0) || (c == 3), rand_word());

        // reset while a sample is in flight
        drive(1'b0, 1'b1, rand_word());
        drive(1'b0, 1'b0, rand_word());
        drive(1'b1, 1'b1, rand_word());
        for (int c = 0; c < 6; c++) drive(1'b0, 1'b0, rand_word());
        check_eq("flush_count", {48'd0, sample_count}, 64'd0);

        // randomized traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)), rand_word());
        end

        // counter wrap: 65535 samples, then one more
        drive(1'b1, 1'b0, '0);
        chk_en = 1'b0;
        for (int c = 0; c < 65535; c++) drive(1'b0, 1'b1, rand_word());
        for (int c = 0; c < L + 1; c++) drive(1'b0, 1'b0, rand_word());
        chk_en = 1'b1;
        check_eq("count_full", {48'd0, sample_count}, 64'h0000_0000_0000_FFFF);
        drive(1'b0, 1'b1, rand_word());
        for (int c = 0; c < L + 1; c++) drive(1'b0, 1'b0, rand_word());
        check_eq("count_wrap", {48'd0, sample_count}, 64'd0);

        // N=3, STEP=2 instance: lanes at cycles 0, 2, 4
        rst = 1'b0; in_valid = 1'b0;
        tick();
        rst2 = 1'b0;
        for (int c = 0; c < 9; c++) begin
            logic [31:0] r2;
            r2 = $urandom();
            din2 = r2[23:0];
            if (c == 0) din2[7:0]   = 8'hA1;
            if (c == 2) din2[15:8]  = 8'hB2;
            if (c == 4) din2[23:16] = 8'hC3;
            in_valid2 = (c == 0);
            tick();
            check_eq("s2_out_valid", {63'd0, out_valid2}, {63'd0, c == 4});
            check_eq("s2_busy", {63'd0, busy2}, {63'd0, c <= 4});
            if (c == 4) check_eq("s2_dout", {40'd0, dout2}, 64'h0000_0000_00C3_B2A1);
        end
        check_eq("s2_count", {48'd0, sample_count2}, 64'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
